// File: rtl/dma_copy_engine.sv
// Single-channel word-copy DMA: CPU-programmed SRC/DST/LEN, then read/capture/write one word per 3 cycles.
// Master strobes are single-cycle and gated by BusGnt; ABORT stops cleanly at the next word boundary.
module dma_copy_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Intr,
  output logic        BusReq,
  input  logic        BusGnt,
  output logic [31:0] MAddr,
  output logic        MRead,
  output logic        MWrite,
  output logic [3:0]  MBe,
  output logic [31:0] MWData,
  input  logic [31:0] MRData
);

  typedef enum logic [2:0] {IDLE, REQ, RD, CAP, WR} state_t;

  state_t      state, state_nxt;
  logic [31:0] src, dst, data;
  logic [15:0] len;
  logic        done, ie, abort_pend;

  logic        busy, wr_en, ctrl_wr, start_wr, abort_wr, done_clr, abort_req;
  logic [1:0]  wr_sel;
  logic        rd_stb, wr_stb, word_done, go, done_set;
  logic        unused_addr;

  assign unused_addr = ^{Addr[11:4], Addr[1:0]};

  assign busy      = (state != IDLE);
  assign wr_en     = ~CS_N & ~WR_N;
  assign wr_sel    = Addr[3:2];
  assign ctrl_wr   = wr_en & (wr_sel == 2'd3);
  assign start_wr  = ctrl_wr & DataIn[0];
  assign done_clr  = ctrl_wr & DataIn[2];
  assign abort_wr  = ctrl_wr & DataIn[4];
  assign abort_req = abort_pend | abort_wr;

  always_comb begin
    state_nxt = state;
    rd_stb    = 1'b0;
    wr_stb    = 1'b0;
    word_done = 1'b0;
    go        = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start_wr) begin
          if (len != 16'd0) begin
            state_nxt = REQ;
            go        = 1'b1;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      REQ: begin
        if (abort_req)   state_nxt = IDLE;
        else if (BusGnt) state_nxt = RD;
      end
      RD: begin
        if (BusGnt) begin
          rd_stb    = 1'b1;
          state_nxt = CAP;
        end
      end
      CAP: state_nxt = WR;
      WR: begin
        if (BusGnt) begin
          wr_stb    = 1'b1;
          word_done = 1'b1;
          // Completion takes priority over a pending abort on the last word.
          if (len == 16'd1) begin
            state_nxt = IDLE;
            done_set  = 1'b1;
          end else if (abort_req) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      src        <= 32'h0;
      dst        <= 32'h0;
      len        <= 16'h0;
      data       <= 32'h0;
      done       <= 1'b0;
      ie         <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (word_done) begin
        src <= src + 32'd4;
        dst <= dst + 32'd4;
        len <= len - 16'd1;
      end else if (wr_en && !busy) begin
        case (wr_sel)
          2'd0:    src <= {DataIn[31:2], 2'b00};
          2'd1:    dst <= {DataIn[31:2], 2'b00};
          2'd2:    len <= DataIn[15:0];
          default: ;
        endcase
      end
      if (state == CAP) data <= MRData;
      if (ctrl_wr) ie <= DataIn[3];
      if (done_set)             done <= 1'b1;
      else if (go || done_clr)  done <= 1'b0;
      if (state_nxt == IDLE)        abort_pend <= 1'b0;
      else if (abort_wr && busy)    abort_pend <= 1'b1;
    end
  end

  always_comb begin
    DataOut = 32'h0;
    if (!CS_N && !RD_N) begin
      case (Addr[3:2])
        2'd0:    DataOut = src;
        2'd1:    DataOut = dst;
        2'd2:    DataOut = {16'h0, len};
        default: DataOut = {27'h0, 1'b0, ie, done, busy, 1'b0};
      endcase
    end
  end

  assign BusReq = busy;
  assign MRead  = rd_stb;
  assign MWrite = wr_stb;
  assign MBe    = (rd_stb | wr_stb) ? 4'hF : 4'h0;
  assign MAddr  = rd_stb ? src : (wr_stb ? dst : 32'h0);
  assign MWData = wr_stb ? data : 32'h0;
  assign Intr   = ~(done & ie);

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 The module SHALL have the following ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- CS_N  input  1  register-port chip select, active low
- RD_N  input  1  register read strobe, active low
- WR_N  input  1  register write strobe, active low
- Addr  input  12  register byte address; only [3:2] decoded
- DataIn  input  32  register write data
- DataOut  output  32  register read data
- Intr  output  1  interrupt, active low
- BusReq  output  1  bus-master request
- BusGnt  input  1  bus-master grant
- MAddr  output  32  master word address; [1:0] always 0
- MRead  output  1  master read strobe, active high
- MWrite  output  1  master write strobe, active high
- MBe  output  4  master byte enables; always 4'b1111 while a strobe is active, else 0
- MWData  output  32  master write data
- MRData  input  32  master read data, valid exactly one cycle after the MRead cycle

REQ-002 The design SHALL use one clock (clk); reset SHALL be synchronous and active-low.

Function
REQ-003 The register map SHALL be: 0x0 SRC[31:0]; 0x4 DST[31:0]; 0x8 LEN[15:0] in words; 0xC CTRL/STATUS with bit0 START (W1, reads 0), bit1 BUSY (RO), bit2 DONE (W1C), bit3 IE (RW), bit4 ABORT (W1, reads 0).
REQ-004 A register write SHALL occur on a clk edge when CS_N=0 and WR_N=0.
REQ-005 SRC[1:0] and DST[1:0] SHALL be forced to 0 on write.
REQ-006 Writes to SRC, DST or LEN while BUSY=1 SHALL be ignored.
REQ-007 DataOut SHALL be combinational, equal to the addressed register when CS_N=0 and RD_N=0, else 32'h0; unused bits SHALL read 0.
REQ-008 SRC, DST and LEN SHALL read back live progress during a transfer.
REQ-009 FSM states SHALL be IDLE, REQ, RD, CAP, WR.
REQ-010 IDLE: START written with LEN!=0 -> REQ, BUSY=1, DONE cleared; START with LEN=0 -> DONE=1 with no bus activity; START while BUSY=1 -> ignored.
REQ-011 BusReq SHALL be 1 in every state except IDLE.
REQ-012 REQ -> RD on the first cycle BusGnt=1.
REQ-013 RD with BusGnt=1: MRead=1 and MAddr=SRC for exactly one cycle, then -> CAP.
REQ-014 RD with BusGnt=0: no strobe; the FSM SHALL remain in RD.
REQ-015 CAP: capture MRData into an internal data register; no strobe; -> WR.
REQ-016 WR with BusGnt=1: MWrite=1, MAddr=DST, MWData=captured data for one cycle; SRC+=4, DST+=4, LEN-=1.
REQ-017 WR: if the new LEN=0 -> IDLE with BUSY=0 and DONE=1; else -> RD.
REQ-018 WR with BusGnt=0: no strobe; the FSM SHALL remain in WR.
REQ-019 Per-word throughput SHALL be 3 cycles with continuous grant.
REQ-020 SRC/DST increments SHALL wrap modulo 2^32.
REQ-021 MRead and MWrite SHALL never be asserted simultaneously.
REQ-022 ABORT written while BUSY=1 SHALL take effect at the next word boundary (after the WR of the current word, or immediately if in REQ) -> IDLE with BUSY=0, DONE unchanged, and registers holding progress.
REQ-023 ABORT written while idle SHALL have no effect.
REQ-024 Intr SHALL equal ~(DONE & IE).
REQ-025 If a DONE-set event and a DONE W1C occur in the same cycle, set SHALL win.
REQ-026 MAddr, MWData, MBe SHALL be 0 when no strobe is active.

Reset
REQ-027 On reset=0 at a clk edge: FSM -> IDLE; SRC, DST, LEN, data register = 0; BUSY, DONE, IE = 0; BusReq, MRead, MWrite = 0; Intr = 1.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no further strobes from the next cycle on.

Verification
REQ-029 SRC=0x100, DST=0x200, LEN=3, IE=1, BusGnt=1 held, START -> reads at 0x100/0x104/0x108 each followed by a write of the same data to 0x200/0x204/0x208; DONE=1 and Intr=0 on cycle 10 after REQ.
REQ-030 LEN=0, START -> DONE=1 next cycle; BusReq never asserted.
REQ-031 BusGnt dropped for 4 cycles during WR -> MWrite held off 4 cycles, then a single write with unchanged data.
REQ-032 SRC=0xFFFFFFFC, LEN=2 -> second read at MAddr=0x00000000.
REQ-033 LEN=5, ABORT written during word 2 -> exactly 2 writes; BUSY=0, DONE=0, LEN reads 3.
REQ-034 reset=0 asserted during CAP -> no MWrite; all registers read 0; Intr=1.
